// File: rtl/transpose_stream.sv
// Streaming tile transposer: ROWS input row beats of COLS elements in, COLS column beats of ROWS elements out.
// Define TRANSPOSE_PINGPONG_EN for two banks (fill one while draining the other); default is a single bank.
//
// bank state | meaning
// EMPTY      | no rows held, accepting the first row of a tile
// FILLING    | some rows held, accepting further rows
// FULL       | all ROWS rows held, no column emitted yet
// DRAINING   | some columns emitted, emitting further columns
module transpose_stream #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COLS*DATA_WIDTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROWS*DATA_WIDTH-1:0]   out_data,
    output logic                         out_last,
    output logic                         busy
);

`ifdef TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t             state [NB];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [RW-1:0]           wr_row;
    logic [CW-1:0]           rd_row;
    logic [DATA_WIDTH-1:0]   mem [NB][ROWS][COLS];

    logic wr_fire, rd_fire, wr_last, rd_last;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_last = (wr_row == RW'(ROWS - 1));
    assign rd_last = (rd_row == CW'(COLS - 1));

    // Handshake outputs decode registered bank state only; out_ready never reaches in_ready.
    assign in_ready  = (state[wr_ptr] == EMPTY) || (state[wr_ptr] == FILLING);
    assign out_valid = (state[rd_ptr] == FULL)  || (state[rd_ptr] == DRAINING);
    assign out_last  = out_valid && rd_last;

    always_comb begin
        busy = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (state[b] != EMPTY) busy = 1'b1;
        end
    end

    // A bank is either writable or readable, never both, so write and drain of
    // different banks on the same edge update independent state entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) state[b] <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            wr_row <= '0;
            rd_row <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr_fire && (wr_ptr == 1'(b)))
                    state[b] <= wr_last ? FULL : FILLING;
                else if (rd_fire && (rd_ptr == 1'(b)))
                    state[b] <= rd_last ? EMPTY : DRAINING;
            end
            if (wr_fire) begin
                wr_row <= wr_last ? '0 : wr_row + RW'(1);
                if (wr_last && (NB == 2)) wr_ptr <= ~wr_ptr;
            end
            if (rd_fire) begin
                rd_row <= rd_last ? '0 : rd_row + CW'(1);
                if (rd_last && (NB == 2)) rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < COLS; c++)
                mem[wr_ptr][wr_row][c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROWS; r++)
            out_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr][r][rd_row];
    end

endmodule

// File: tb/tb_transpose_stream.sv
// Directed bench for transpose_stream (ROWS=4, COLS=3, DATA_WIDTH=8); expectations follow
// the build selected by TRANSPOSE_PINGPONG_EN.
module tb_transpose_stream;
    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int DW   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [COLS*DW-1:0]    in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [ROWS*DW-1:0]    out_data;
    logic                  out_last;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;

    // Tile 0: 1..12, tile 1: 13..24, tile 2: signed extremes. Element 0 is the low byte.
    logic [23:0] rows_t [3][4] = '{
        '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A},
        '{24'h0F0E0D, 24'h121110, 24'h151413, 24'h181716},
        '{24'h007F80, 24'h01807F, 24'h8001FF, 24'h7FFF00}
    };
    logic [31:0] beats_t [3][3] = '{
        '{32'h0A070401, 32'h0B080502, 32'h0C090603},
        '{32'h1613100D, 32'h1714110E, 32'h1815120F},
        '{32'h00FF7F80, 32'hFF01807F, 32'h7F800100}
    };

`ifdef TRANSPOSE_PINGPONG_EN
    localparam int TILE_PERIOD = 4;
    localparam int EXP_STALLS  = 0;
    localparam logic RDY_FULL  = 1'b1;
`else
    localparam int TILE_PERIOD = 7;
    localparam int EXP_STALLS  = 6;
    localparam logic RDY_FULL  = 1'b0;
`endif

    transpose_stream #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (in_valid && !in_ready) stalls <= stalls + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_row(input logic [23:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic get_beat(input string tag, input logic [31:0] exp_d, input logic exp_last,
                            output int edge_no);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_last"}, 32'(out_last), 32'(exp_last));
        edge_no = cyc + 1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int e, t0, s0;

        // reset state
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // single tile, one-cycle fill-to-drain latency
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) put_row(rows_t[0][r]);
        chk("t1_early_valid", 32'(out_valid), 32'd0);
        put_row(rows_t[0][3]);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready_full", 32'(in_ready), 32'(RDY_FULL));
        for (int c = 0; c < 3; c++) get_beat("t1_beat", beats_t[0][c], c == 2, e);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // back-pressure on beat 1
        for (int r = 0; r < 4; r++) put_row(rows_t[1][r]);
        get_beat("bp_beat0", beats_t[1][0], 1'b0, e);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", out_data, beats_t[1][1]);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        get_beat("bp_beat1", beats_t[1][1], 1'b0, e);
        get_beat("bp_beat2", beats_t[1][2], 1'b1, e);

        // three back-to-back tiles; output idles between tiles because COLS < ROWS
        t0 = cyc;
        s0 = stalls;
        fork
            begin
                for (int t = 0; t < 3; t++)
                    for (int r = 0; r < 4; r++) put_row(rows_t[t][r]);
            end
            begin
                int be;
                for (int t = 0; t < 3; t++)
                    for (int c = 0; c < 3; c++) begin
                        get_beat("st_beat", beats_t[t][c], c == 2, be);
                        chk("st_edge", 32'(be - t0), 32'(5 + TILE_PERIOD * t + c));
                    end
            end
        join
        step();
        chk("st_stalls", 32'(stalls - s0), 32'(EXP_STALLS));
        chk("st_idle_busy", 32'(busy), 32'd0);

        // reset mid-tile discards the partial tile
        put_row(rows_t[1][0]);
        put_row(rows_t[1][1]);
        chk("mr_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy_async", 32'(busy), 32'd0);
        chk("mr_valid_async", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_out_valid", 32'(out_valid), 32'd0);

        // fresh tile of signed extremes
        for (int r = 0; r < 4; r++) put_row(rows_t[2][r]);
        chk("sg_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 3; c++) get_beat("sg_beat", beats_t[2][c], c == 2, e);
        chk("sg_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
